// File: rtl/audio_pkg.sv
// Shared types and constants for the on-board I2S audio path.
//   I2S_FRAME_BITS / I2S_SLOT_BITS : frame geometry (32 BCK per frame, 16 per slot)
//   sample_pair_t                  : one left/right 16-bit sample pair
//   tx_state_t                     : serializer framing state
//   sat16()                        : clamp a 17-bit signed value to 16-bit signed
package audio_pkg;

    localparam int unsigned I2S_FRAME_BITS = 32;
    localparam int unsigned I2S_SLOT_BITS  = 16;

    typedef struct packed {
        logic [15:0] l;
        logic [15:0] r;
    } sample_pair_t;

    // TX_WAIT: no frame started since reset; TX_FRAME: pos tracks a live frame
    typedef enum logic {
        TX_WAIT,
        TX_FRAME
    } tx_state_t;

    // Overflow exactly when the two top bits disagree; the sign picks the rail.
    function automatic logic [15:0] sat16(input logic signed [16:0] v);
        if (v[16] != v[15]) begin
            return v[16] ? 16'h8000 : 16'h7FFF;
        end
        return v[15:0];
    endfunction

endpackage

// File: rtl/audio_pair_fifo.sv
// Circular sample-pair buffer between the sample producer and the I2S serializer.
//   clk, rst_n    : clock, asynchronous active-low reset (clears all entries)
//   push, wdata   : write a pair; ignored while full
//   pop, rdata    : rdata shows the oldest pair; pop ignored while empty
//   count         : occupancy 0..DEPTH
//   full, empty   : occupancy flags
module audio_pair_fifo
    import audio_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  sample_pair_t                 wdata,
    input  logic                         pop,
    output sample_pair_t                 rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    sample_pair_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/audio_i2s_tx.sv
// Single-clock I2S transmitter for the headphone/amplifier DAC.
//   clk        : pixel clock, the only clock
//   pll_lock   : asynchronous active-low reset
//   bck_div    : BCK half-period minus 1 in clk cycles (0 behaves as 1)
//   in_l/in_r  : signed 16-bit sample pair; in_valid/in_ready handshake
//   hp_bck     : bit clock; hp_ws word select (0 = left); hp_din MSB-first data
//   pa_en      : amplifier enable (inverted polarity in stereo builds)
//   frame_tick : 1-clk pulse when a frame starts at position 0
//   underrun   : 1-clk pulse when a frame starts with no queued pair
module audio_i2s_tx
    import audio_pkg::*;
#(
    parameter bit          STEREO     = 1'b0,
    parameter int unsigned SHIFT      = 3,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        pll_lock,
    input  logic [7:0]  bck_div,
    input  logic [15:0] in_l,
    input  logic [15:0] in_r,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        hp_bck,
    output logic        hp_ws,
    output logic        hp_din,
    output logic        pa_en,
    output logic        frame_tick,
    output logic        underrun
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    logic          running;
    logic [7:0]    div_cnt;
    logic [7:0]    div_max;
    logic          div_hit;
    logic          shift_tick;
    tx_state_t     state;
    tx_state_t     state_next;
    logic [4:0]    pos;
    logic [4:0]    pos_next;
    logic          frame_start;
    logic [31:0]   w;
    logic [31:0]   w_next;
    sample_pair_t  fifo_wdata;
    sample_pair_t  fifo_rdata;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count_unused;
    logic          push;
    logic          pop;

    assign div_max    = (bck_div == 8'd0) ? 8'd1 : bck_div;
    assign div_hit    = (div_cnt >= div_max);
    // BCK is about to fall: data and word select move with the falling edge
    assign shift_tick = div_hit && hp_bck;

    assign in_ready   = running && !fifo_full;
    assign pa_en      = STEREO ? ~running : running;
    assign push       = in_valid && in_ready;
    assign pop        = frame_start && !fifo_empty;
    assign fifo_wdata = {in_l, in_r};

    // Level output kept on the FIFO for status taps; flags suffice here.
    audio_pair_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (pll_lock),
        .push  (push),
        .wdata (fifo_wdata),
        .pop   (pop),
        .rdata (fifo_rdata),
        .count (fifo_count_unused),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    function automatic logic [31:0] fmt(input sample_pair_t p);
        logic signed [15:0] sl;
        logic signed [15:0] sr;
        logic signed [16:0] m;
        logic [15:0]        s;
        sl = $signed(p.l) >>> SHIFT;
        sr = $signed(p.r) >>> SHIFT;
        m  = $signed({p.l[15], p.l}) + $signed({p.r[15], p.r});
        s  = sat16(m >>> SHIFT);
        return STEREO ? {sl, sr} : {s, s};
    endfunction

    always_ff @(posedge clk or negedge pll_lock) begin
        if (!pll_lock) begin
            state <= TX_WAIT;
            pos   <= '0;
        end else begin
            state <= state_next;
            pos   <= pos_next;
        end
    end

    // The first shift tick after reset opens frame position 0 directly;
    // afterwards a frame starts on the 31 -> 0 wrap.
    always_comb begin
        state_next  = state;
        pos_next    = pos;
        frame_start = 1'b0;
        if (shift_tick) begin
            case (state)
                TX_WAIT: begin
                    state_next  = TX_FRAME;
                    pos_next    = '0;
                    frame_start = 1'b1;
                end
                default: begin
                    pos_next    = pos + 5'd1;
                    frame_start = (pos == 5'd31);
                end
            endcase
        end
    end

    // An empty FIFO at frame start keeps the previous word.
    always_comb begin
        w_next = w;
        if (pop) begin
            w_next = fmt(fifo_rdata);
        end
    end

    always_ff @(posedge clk or negedge pll_lock) begin
        if (!pll_lock) begin
            running    <= 1'b0;
            div_cnt    <= '0;
            hp_bck     <= 1'b0;
            hp_ws      <= 1'b0;
            hp_din     <= 1'b0;
            frame_tick <= 1'b0;
            underrun   <= 1'b0;
            w          <= '0;
        end else begin
            running <= 1'b1;
            if (div_hit) begin
                div_cnt <= '0;
                hp_bck  <= ~hp_bck;
            end else begin
                div_cnt <= div_cnt + 8'd1;
            end
            w          <= w_next;
            frame_tick <= frame_start;
            underrun   <= frame_start && fifo_empty;
            if (shift_tick) begin
                hp_din <= w_next[5'(I2S_FRAME_BITS - 1) - pos_next];
                // WS flips one BCK ahead of each slot's MSB
                hp_ws  <= (pos_next >= 5'(I2S_SLOT_BITS - 1)) &&
                          (pos_next <= 5'(I2S_FRAME_BITS - 2));
            end
        end
    end

endmodule

// File: tb/tb_audio_i2s_tx.sv
module tb_audio_i2s_tx;

    localparam int DEPTH = 2;

    // word index 0: stereo SHIFT=0, 1: mono SHIFT=0, 2: mono SHIFT=3
    typedef logic [2:0][31:0] wtrip_t;
    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        wtrip_t      w;
    } vec_t;

    logic        clk = 1'b0;
    logic        pll_lock;
    logic [7:0]  bck_div;
    logic [15:0] in_l;
    logic [15:0] in_r;
    logic        in_valid;
    logic [2:0]  in_ready, hp_bck, hp_ws, hp_din, pa_en, frame_tick, underrun;

    always #5 clk = ~clk;

    audio_i2s_tx #(.STEREO(1'b1), .SHIFT(0), .FIFO_DEPTH(DEPTH)) u_st (
        .clk(clk), .pll_lock(pll_lock), .bck_div(bck_div), .in_l(in_l), .in_r(in_r),
        .in_valid(in_valid), .in_ready(in_ready[0]), .hp_bck(hp_bck[0]), .hp_ws(hp_ws[0]),
        .hp_din(hp_din[0]), .pa_en(pa_en[0]), .frame_tick(frame_tick[0]), .underrun(underrun[0]));

    audio_i2s_tx #(.STEREO(1'b0), .SHIFT(0), .FIFO_DEPTH(DEPTH)) u_m0 (
        .clk(clk), .pll_lock(pll_lock), .bck_div(bck_div), .in_l(in_l), .in_r(in_r),
        .in_valid(in_valid), .in_ready(in_ready[1]), .hp_bck(hp_bck[1]), .hp_ws(hp_ws[1]),
        .hp_din(hp_din[1]), .pa_en(pa_en[1]), .frame_tick(frame_tick[1]), .underrun(underrun[1]));

    audio_i2s_tx #(.STEREO(1'b0), .SHIFT(3), .FIFO_DEPTH(DEPTH)) u_m3 (
        .clk(clk), .pll_lock(pll_lock), .bck_div(bck_div), .in_l(in_l), .in_r(in_r),
        .in_valid(in_valid), .in_ready(in_ready[2]), .hp_bck(hp_bck[2]), .hp_ws(hp_ws[2]),
        .hp_din(hp_din[2]), .pa_en(pa_en[2]), .frame_tick(frame_tick[2]), .underrun(underrun[2]));

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    endtask

    // ---------------- stimulus table ----------------
    vec_t tbl [8];

    function automatic vec_t mk(input logic [15:0] l, input logic [15:0] r,
                                input logic [31:0] st, input logic [31:0] m0,
                                input logic [31:0] m3);
        vec_t v;
        v.l = l;
        v.r = r;
        v.w[0] = st;
        v.w[1] = m0;
        v.w[2] = m3;
        return v;
    endfunction

    // ---------------- scoreboard / monitor ----------------
    wtrip_t      q[$];
    wtrip_t      drv_exp;
    wtrip_t      pre_exp;
    wtrip_t      last_w;
    wtrip_t      cur_exp;
    wtrip_t      rx;
    logic [31:0] rx_ws;
    logic        pre_valid;
    logic        prev_bck;
    bit          m_run;
    bit          acc;
    bit          collecting;
    int          nbits;
    int          n_frames = 0;

    always @(posedge clk or negedge pll_lock) begin
        if (!pll_lock) begin
            m_run      = 1'b0;
            q.delete();
            last_w     = '0;
            collecting = 1'b0;
            acc        = 1'b0;
            prev_bck   = 1'b0;
            nbits      = 0;
        end else begin
            pre_valid = in_valid;
            pre_exp   = drv_exp;
            acc       = pre_valid && m_run && (q.size() < DEPTH);
            m_run     = 1'b1;
            #1;
            // pop decision uses the queue as it stood before this edge's push
            if (frame_tick[0]) begin
                check("underrun_at_frame", {31'd0, underrun[0]}, {31'd0, q.size() == 0});
                if (q.size() != 0) last_w = q.pop_front();
                cur_exp    = last_w;
                collecting = 1'b1;
                nbits      = 0;
                n_frames++;
            end else if (underrun[0]) begin
                check("underrun_without_frame", {31'd0, underrun[0]}, 32'd0);
            end
            if (acc) q.push_back(pre_exp);
            if (in_valid)
                check("in_ready", {31'd0, in_ready[0]}, {31'd0, (m_run && q.size() < DEPTH)});
            if (collecting && hp_bck[0] && !prev_bck) begin
                for (int k = 0; k < 3; k++) rx[k] = {rx[k][30:0], hp_din[k]};
                rx_ws = {rx_ws[30:0], hp_ws[0]};
                nbits++;
                if (nbits == 32) begin
                    check("word_stereo_s0", rx[0], cur_exp[0]);
                    check("word_mono_s0",   rx[1], cur_exp[1]);
                    check("word_mono_s3",   rx[2], cur_exp[2]);
                    check("ws_pattern",     rx_ws, 32'h0001_FFFE);
                    collecting = 1'b0;
                end
            end
            prev_bck = hp_bck[0];
        end
    end

    // ---------------- helpers ----------------
    task automatic push_pair(input int idx, output int waits);
        @(negedge clk);
        in_l     = tbl[idx].l;
        in_r     = tbl[idx].r;
        drv_exp  = tbl[idx].w;
        in_valid = 1'b1;
        waits    = 0;
        do begin
            @(posedge clk);
            #2;
            waits++;
        end while (!acc && waits < 2000);
        in_valid = 1'b0;
        if (!acc) check("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_rise(output int at);
        logic p;
        at = -1;
        p  = hp_bck[0];
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            if (hp_bck[0] && !p) begin
                at = cyc;
                break;
            end
            p = hp_bck[0];
        end
        if (at < 0) check("bck_rise_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_tick(output int at);
        at = -1;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            if (frame_tick[0]) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check("frame_tick_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_bits(input int n);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #2;
            if (collecting && nbits == n) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) check("bit_position_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int t0, t1, w;

        //                L         R         stereo s0     mono s0       mono s3
        tbl[0] = mk(16'h8001, 16'h7FFE, 32'h8001_7FFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        tbl[1] = mk(16'h7FFF, 16'h7FFF, 32'h7FFF_7FFF, 32'h7FFF_7FFF, 32'h1FFF_1FFF);
        tbl[2] = mk(16'h8000, 16'h8000, 32'h8000_8000, 32'h8000_8000, 32'hE000_E000);
        tbl[3] = mk(16'h4000, 16'h4000, 32'h4000_4000, 32'h7FFF_7FFF, 32'h1000_1000);
        tbl[4] = mk(16'h1234, 16'h0000, 32'h1234_0000, 32'h1234_1234, 32'h0246_0246);
        tbl[5] = mk(16'hFFF0, 16'h0005, 32'hFFF0_0005, 32'hFFF5_FFF5, 32'hFFFE_FFFE);
        tbl[6] = mk(16'hC000, 16'hC001, 32'hC000_C001, 32'h8001_8001, 32'hF000_F000);
        tbl[7] = mk(16'h7FFF, 16'h0001, 32'h7FFF_0001, 32'h7FFF_7FFF, 32'h1000_1000);

        pll_lock = 1'b0;
        bck_div  = 8'd3;
        in_l     = '0;
        in_r     = '0;
        in_valid = 1'b0;
        drv_exp  = '0;

        // reset state
        repeat (10) @(posedge clk);
        #1;
        check("rst_hp_bck",     {29'd0, hp_bck},     32'd0);
        check("rst_hp_ws",      {29'd0, hp_ws},      32'd0);
        check("rst_hp_din",     {29'd0, hp_din},     32'd0);
        check("rst_in_ready",   {29'd0, in_ready},   32'd0);
        check("rst_frame_tick", {29'd0, frame_tick}, 32'd0);
        check("rst_underrun",   {29'd0, underrun},   32'd0);
        check("rst_pa_en",      {29'd0, pa_en},      32'b001);

        @(negedge clk);
        pll_lock = 1'b1;
        @(posedge clk);
        #1;
        check("release_in_ready", {31'd0, in_ready[0]}, 32'd1);
        check("release_pa_en",    {29'd0, pa_en},       32'b110);

        // divider and frame timing
        wait_rise(t0);
        wait_rise(t1);
        check("bck_period_div3", t1 - t0, 32'd8);
        wait_tick(t0);
        wait_tick(t1);
        check("frame_period_div3", t1 - t0, 32'd256);

        @(negedge clk);
        bck_div = 8'd0;
        wait_rise(t0);
        wait_rise(t0);
        wait_rise(t1);
        check("bck_period_div0", t1 - t0, 32'd4);
        @(negedge clk);
        bck_div = 8'd3;
        wait_rise(t0);
        wait_rise(t0);
        wait_rise(t1);
        check("bck_period_div3_again", t1 - t0, 32'd8);

        // table vectors through the scoreboard
        for (int i = 0; i < 8; i++) push_pair(i, w);
        repeat (3) wait_tick(t0);

        // flow control: two fit, the third waits for the next frame start
        wait_tick(t0);
        push_pair(0, w);
        check("fc_first_wait", w, 32'd1);
        push_pair(1, w);
        check("fc_second_wait", w, 32'd1);
        check("fc_ready_low_full", {31'd0, in_ready[0]}, 32'd0);
        push_pair(2, w);
        check("fc_third_wait", w, 32'd255);
        repeat (5) wait_tick(t0);

        // reset in the middle of a frame with two pairs queued
        wait_tick(t0);
        push_pair(3, w);
        push_pair(4, w);
        wait_bits(21);
        @(negedge clk);
        pll_lock = 1'b0;
        #1;
        check("midrst_hp_bck",     {29'd0, hp_bck},     32'd0);
        check("midrst_hp_ws",      {29'd0, hp_ws},      32'd0);
        check("midrst_hp_din",     {29'd0, hp_din},     32'd0);
        check("midrst_in_ready",   {29'd0, in_ready},   32'd0);
        check("midrst_frame_tick", {29'd0, frame_tick}, 32'd0);
        check("midrst_underrun",   {29'd0, underrun},   32'd0);
        check("midrst_pa_en",      {29'd0, pa_en},      32'b001);
        repeat (5) @(negedge clk);
        pll_lock = 1'b1;
        repeat (3) wait_tick(t0);

        check("frames_seen", {31'd0, n_frames >= 15}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
